uart: RTL and testbench

Configurable 8-bit UART receiver that deserialises the asynchronous line `in` into bytes for the VGA/colour-display path. Incoming bytes are handed to a consumer that acknowledges on edges of `clkinVGA`. A small write-only register port sets baud divisor, parity, stop bits and control. Line errors are reported with a 4-bit code and a strobe.

---
 rtl/uart_if.sv | 24 ++
 rtl/uart.sv | 204 ++++++++++++++++++++
 tb/tb_uart.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_if.sv
// Bundle of the UART receiver's serial line, consumer handshake, config port and result signals.
// master drives the line and config; slave is the receiver.
interface uart_if;
  logic       in;
  logic       clkinVGA;
  logic       c_valid;
  logic [1:0] c_addr;
  logic [7:0] c_data;
  logic       c_ready;
  logic [3:0] error;
  logic       ready_error;
  logic [7:0] out;
  logic       ready_out;

  modport master (
    output in, clkinVGA, c_valid, c_addr, c_data,
    input  c_ready, error, ready_error, out, ready_out
  );

  modport slave (
    input  in, clkinVGA, c_valid, c_addr, c_data,
    output c_ready, error, ready_error, out, ready_out
  );
endinterface

// File: rtl/uart.sv
// Configurable 8-bit UART receiver with register-programmed divisor, parity and stop bits.
// Good bytes are held in out/ready_out until the consumer's clkinVGA rising edge.
module uart (
  input logic   clk,
  input logic   rst,
  uart_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

  state_t     r_state;
  logic       r_in_s1, r_in_s2, r_in_prev;
  logic       r_vga_s1, r_vga_s2, r_vga_prev;
  logic [7:0] r_div, r_fdiv;
  logic [1:0] r_par, r_fpar;
  logic       r_stop, r_fstop, r_en;
  logic       r_armed;
  logic [7:0] r_arm_cnt, r_cnt, r_shift;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx, r_perr, r_ferr, r_done;
  logic       r_c_ready, r_ready_error, r_ready_out;
  logic [3:0] r_error;
  logic [7:0] r_out;

  logic       w_fall, w_vga_rise, w_par_exp, w_good, w_ovr;
  logic [3:0] w_code;
  logic [8:0] w_arm_next;

  always_comb begin
    w_fall     = r_in_prev & ~r_in_s2;
    w_vga_rise = r_vga_s2 & ~r_vga_prev;
    w_par_exp  = (r_fpar == 2'd2) ? ~^r_shift : ^r_shift;
    w_good     = ~r_ferr & ~r_perr;
    // A consume in the same cycle as completion means the old byte was taken: no overrun.
    w_ovr      = w_good & r_ready_out & ~w_vga_rise;
    w_code     = {1'b0, w_ovr, r_perr, r_ferr};
    w_arm_next = {1'b0, r_arm_cnt} + 9'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_in_s1       <= 1'b1;
      r_in_s2       <= 1'b1;
      r_in_prev     <= 1'b1;
      r_vga_s1      <= 1'b0;
      r_vga_s2      <= 1'b0;
      r_vga_prev    <= 1'b0;
      r_div         <= 8'd16;
      r_fdiv        <= 8'd16;
      r_par         <= 2'd0;
      r_fpar        <= 2'd0;
      r_stop        <= 1'b0;
      r_fstop       <= 1'b0;
      r_en          <= 1'b1;
      r_armed       <= 1'b0;
      r_arm_cnt     <= 8'd0;
      r_cnt         <= 8'd0;
      r_shift       <= 8'd0;
      r_bit_idx     <= 3'd0;
      r_stop_idx    <= 1'b0;
      r_perr        <= 1'b0;
      r_ferr        <= 1'b0;
      r_done        <= 1'b0;
      r_c_ready     <= 1'b1;
      r_ready_error <= 1'b0;
      r_ready_out   <= 1'b0;
      r_error       <= 4'd0;
      r_out         <= 8'd0;
    end else begin
      r_in_s1       <= bus.in;
      r_in_s2       <= r_in_s1;
      r_in_prev     <= r_in_s2;
      r_vga_s1      <= bus.clkinVGA;
      r_vga_s2      <= r_vga_s1;
      r_vga_prev    <= r_vga_s2;
      r_ready_error <= 1'b0;
      r_done        <= 1'b0;

      if (bus.c_valid && r_c_ready) begin
        unique case (bus.c_addr)
          2'd0: r_div  <= (bus.c_data < 8'd4) ? 8'd4 : bus.c_data;
          2'd1: r_par  <= bus.c_data[1:0];
          2'd2: r_stop <= bus.c_data[0];
          2'd3: begin
            r_en <= bus.c_data[0];
            if (bus.c_data[1]) begin
              r_ready_out <= 1'b0;
              r_error     <= 4'd0;
            end
          end
          default: ;
        endcase
      end

      if (w_vga_rise) r_ready_out <= 1'b0;

      // Outputs land one clock after the final stop sample; later writes win.
      if (r_done) begin
        if (w_good) begin
          r_out       <= r_shift;
          r_ready_out <= 1'b1;
        end
        if (w_code != 4'd0) begin
          r_error       <= w_code;
          r_ready_error <= 1'b1;
        end
      end

      if (!r_en) begin
        r_armed   <= 1'b0;
        r_arm_cnt <= 8'd0;
      end else if (!r_armed) begin
        if (r_in_s2) begin
          r_arm_cnt <= r_arm_cnt + 8'd1;
          if (w_arm_next >= {1'b0, r_div}) r_armed <= 1'b1;
        end else begin
          r_arm_cnt <= 8'd0;
        end
      end

      if (!r_en && r_state != StIdle) begin
        r_state   <= StIdle;
        r_c_ready <= 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            if (r_armed && r_en && w_fall) begin
              r_state   <= StStart;
              r_cnt     <= 8'd0;
              r_c_ready <= 1'b0;
              r_fdiv    <= r_div;
              r_fpar    <= r_par;
              r_fstop   <= r_stop;
            end
          end
          StStart: begin
            if (r_cnt == (r_fdiv >> 1) - 8'd1) begin
              r_cnt <= 8'd0;
              if (!r_in_s2) begin
                r_state   <= StData;
                r_bit_idx <= 3'd0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
              end else begin
                r_state       <= StIdle;
                r_c_ready     <= 1'b1;
                r_error       <= 4'b1000;
                r_ready_error <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          StData: begin
            if (r_cnt == r_fdiv - 8'd1) begin
              r_cnt     <= 8'd0;
              r_shift   <= {r_in_s2, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_stop_idx <= 1'b0;
                r_state    <= (r_fpar == 2'd1 || r_fpar == 2'd2) ? StParity : StStop;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          StParity: begin
            if (r_cnt == r_fdiv - 8'd1) begin
              r_cnt   <= 8'd0;
              r_perr  <= (r_in_s2 != w_par_exp);
              r_state <= StStop;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          StStop: begin
            if (r_cnt == r_fdiv - 8'd1) begin
              r_cnt  <= 8'd0;
              r_ferr <= r_ferr | ~r_in_s2;
              if (r_stop_idx == r_fstop) begin
                r_done    <= 1'b1;
                r_state   <= StIdle;
                r_c_ready <= 1'b1;
              end else begin
                r_stop_idx <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.c_ready     = r_c_ready;
  assign bus.error       = r_error;
  assign bus.ready_error = r_ready_error;
  assign bus.out         = r_out;
  assign bus.ready_out   = r_ready_out;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: drives LSB-first serial frames and compares received bytes and
// error codes against expectations derived from the frame contents.
module tb_uart;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vga_line = 1'b0;
  bit   vga_run = 1'b0;

  uart_if bus ();
  assign bus.clkinVGA = vga_line;

  uart dut (.clk(clk), .rst(rst), .bus(bus));

  always #2 clk = ~clk;
  always #36 if (vga_run) vga_line = ~vga_line;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  int   err_pulses = 0;
  int   wide_pulses = 0;
  logic prev_ro = 1'b0;
  logic prev_re = 1'b0;

  // Collect every ready_out rise (with its byte) and every ready_error pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ready_out && !prev_ro) rx_q.push_back(bus.out);
      if (bus.ready_error) err_pulses++;
      if (bus.ready_error && prev_re) wide_pulses++;
    end
    prev_ro = bus.ready_out;
    prev_re = bus.ready_error;
  end

  // Parity bit a transmitter would send: even (1) makes total ones even, odd (2) makes it odd.
  function automatic logic par_bit(input logic [7:0] b, input int mode);
    int ones;
    ones = $countones(b);
    if (mode == 2) return ((ones % 2) == 0);
    return ((ones % 2) == 1);
  endfunction

  task automatic send_frame(input logic [7:0] b, input int pmode, input logic pval,
                            input int nstop, input logic last_stop);
    bus.in = 1'b0;
    #64;
    for (int i = 0; i < 8; i++) begin
      bus.in = b[i];
      #64;
    end
    if (pmode == 1 || pmode == 2) begin
      bus.in = pval;
      #64;
    end
    for (int s = 0; s < nstop; s++) begin
      bus.in = (s == nstop - 1) ? last_stop : 1'b1;
      #64;
    end
    bus.in = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.c_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bus.c_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL cfg_c_ready: c_ready=%b required 1", bus.c_ready);
    end
    bus.c_valid = 1'b1;
    bus.c_addr  = addr;
    bus.c_data  = data;
    @(negedge clk);
    bus.c_valid = 1'b0;
  endtask

  task automatic consume();
    vga_run = 1'b1;
    #150;
    vga_run = 1'b0;
    #20;
  endtask

  task automatic test_reset();
    bus.in = 1'b0;
    bus.c_valid = 1'b0;
    bus.c_addr = 2'd0;
    bus.c_data = 8'd0;
    rst = 1'b1;
    #21;
    n_checks += 5;
    if (bus.out !== 8'h00) begin n_errors++; $display("FAIL reset_out: %h vs 00", bus.out); end
    if (bus.ready_out !== 1'b0) begin n_errors++; $display("FAIL reset_ready_out: %b vs 0", bus.ready_out); end
    if (bus.error !== 4'h0) begin n_errors++; $display("FAIL reset_error: %h vs 0", bus.error); end
    if (bus.ready_error !== 1'b0) begin n_errors++; $display("FAIL reset_ready_error: %b vs 0", bus.ready_error); end
    if (bus.c_ready !== 1'b1) begin n_errors++; $display("FAIL reset_c_ready: %b vs 1", bus.c_ready); end
    rst = 1'b0;
  endtask

  task automatic test_arming();
    #100;
    bus.in = 1'b1;
    #20;
    bus.in = 1'b0;
    #200;
    bus.in = 1'b1;
    #800;
    n_checks += 4;
    if (rx_q.size() !== 0) begin n_errors++; $display("FAIL arm_no_byte: %0d bytes vs 0", rx_q.size()); end
    if (err_pulses !== 0) begin n_errors++; $display("FAIL arm_no_err_pulse: %0d vs 0", err_pulses); end
    if (bus.error !== 4'h0) begin n_errors++; $display("FAIL arm_error: %h vs 0", bus.error); end
    if (bus.ready_out !== 1'b0) begin n_errors++; $display("FAIL arm_ready_out: %b vs 0", bus.ready_out); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    int p0;
    exp_q = '{8'hBA, 8'h55, 8'hAA, 8'hFF, 8'h00};
    rx_q.delete();
    p0 = err_pulses;
    vga_run = 1'b1;
    foreach (exp_q[i]) begin
      send_frame(exp_q[i], 0, 1'b0, 1, 1'b1);
      #($urandom_range(1, 63));
    end
    #300;
    vga_run = 1'b0;
    #20;
    n_checks += 4;
    if (rx_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL stream_count: %0d bytes vs %0d", rx_q.size(), exp_q.size());
    end
    if (err_pulses !== p0) begin n_errors++; $display("FAIL stream_err_pulses: %0d vs %0d", err_pulses, p0); end
    if (bus.error !== 4'h0) begin n_errors++; $display("FAIL stream_error: %h vs 0", bus.error); end
    if (bus.ready_out !== 1'b0) begin n_errors++; $display("FAIL stream_consumed: %b vs 0", bus.ready_out); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL stream_byte%0d: %h vs %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_framing();
    logic [7:0] b;
    int p0;
    b = 8'($urandom_range(1, 255));
    send_frame(b, 0, 1'b0, 1, 1'b1);
    #40;
    p0 = err_pulses;
    send_frame(8'h00, 0, 1'b0, 1, 1'b0);
    #40;
    n_checks += 4;
    if (bus.error !== 4'b0001) begin n_errors++; $display("FAIL frame_error: %b vs 0001", bus.error); end
    if (err_pulses !== p0 + 1) begin n_errors++; $display("FAIL frame_pulses: %0d vs %0d", err_pulses, p0 + 1); end
    if (bus.out !== b) begin n_errors++; $display("FAIL frame_out_kept: %h vs %h", bus.out, b); end
    if (bus.ready_out !== 1'b1) begin n_errors++; $display("FAIL frame_ready_kept: %b vs 1", bus.ready_out); end
    cfg_write(2'd3, 8'h03);
    #8;
    n_checks += 2;
    if (bus.ready_out !== 1'b0) begin n_errors++; $display("FAIL clear_ready_out: %b vs 0", bus.ready_out); end
    if (bus.error !== 4'h0) begin n_errors++; $display("FAIL clear_error: %h vs 0", bus.error); end
  endtask

  task automatic test_parity();
    int p0;
    cfg_write(2'd1, 8'd2);
    send_frame(8'h55, 2, par_bit(8'h55, 2), 1, 1'b1);
    #40;
    n_checks += 3;
    if (bus.out !== 8'h55) begin n_errors++; $display("FAIL par_good_out: %h vs 55", bus.out); end
    if (bus.ready_out !== 1'b1) begin n_errors++; $display("FAIL par_good_ready: %b vs 1", bus.ready_out); end
    if (bus.error !== 4'h0) begin n_errors++; $display("FAIL par_good_error: %h vs 0", bus.error); end
    consume();
    n_checks++;
    if (bus.ready_out !== 1'b0) begin n_errors++; $display("FAIL par_consume: %b vs 0", bus.ready_out); end
    p0 = err_pulses;
    send_frame(8'h55, 2, ~par_bit(8'h55, 2), 1, 1'b1);
    #40;
    n_checks += 3;
    if (bus.error !== 4'b0010) begin n_errors++; $display("FAIL par_bad_error: %b vs 0010", bus.error); end
    if (bus.ready_out !== 1'b0) begin n_errors++; $display("FAIL par_bad_discard: %b vs 0", bus.ready_out); end
    if (err_pulses !== p0 + 1) begin n_errors++; $display("FAIL par_bad_pulses: %0d vs %0d", err_pulses, p0 + 1); end
    cfg_write(2'd1, 8'd0);
  endtask

  task automatic test_overrun();
    int p0;
    p0 = err_pulses;
    send_frame(8'h11, 0, 1'b0, 1, 1'b1);
    #20;
    send_frame(8'h22, 0, 1'b0, 1, 1'b1);
    #40;
    n_checks += 4;
    if (bus.out !== 8'h22) begin n_errors++; $display("FAIL ovr_out: %h vs 22", bus.out); end
    if (bus.error !== 4'b0100) begin n_errors++; $display("FAIL ovr_error: %b vs 0100", bus.error); end
    if (bus.ready_out !== 1'b1) begin n_errors++; $display("FAIL ovr_ready: %b vs 1", bus.ready_out); end
    if (err_pulses !== p0 + 1) begin n_errors++; $display("FAIL ovr_pulses: %0d vs %0d", err_pulses, p0 + 1); end
    cfg_write(2'd3, 8'h03);
    #8;
  endtask

  task automatic test_false_start();
    int p0, n0;
    p0 = err_pulses;
    n0 = rx_q.size();
    bus.in = 1'b0;
    #12;
    bus.in = 1'b1;
    #100;
    n_checks += 3;
    if (bus.error !== 4'b1000) begin n_errors++; $display("FAIL fs_error: %b vs 1000", bus.error); end
    if (err_pulses !== p0 + 1) begin n_errors++; $display("FAIL fs_pulses: %0d vs %0d", err_pulses, p0 + 1); end
    if (rx_q.size() !== n0) begin n_errors++; $display("FAIL fs_no_byte: %0d vs %0d", rx_q.size(), n0); end
    send_frame(8'h3C, 0, 1'b0, 1, 1'b1);
    #40;
    n_checks += 3;
    if (bus.out !== 8'h3C) begin n_errors++; $display("FAIL fs_next_out: %h vs 3c", bus.out); end
    if (bus.ready_out !== 1'b1) begin n_errors++; $display("FAIL fs_next_ready: %b vs 1", bus.ready_out); end
    if (bus.error !== 4'b1000) begin n_errors++; $display("FAIL fs_error_kept: %b vs 1000", bus.error); end
    consume();
  endtask

  task automatic test_random();
    int pmode, nstop, kind, exp_pulses;
    logic [7:0] b, exp_out;
    logic [3:0] exp_err;
    cfg_write(2'd3, 8'h03);
    pmode = $urandom_range(0, 3);
    nstop = $urandom_range(1, 2);
    cfg_write(2'd1, 8'(pmode));
    cfg_write(2'd2, 8'(nstop - 1));
    exp_out = bus.out;
    exp_err = 4'h0;
    exp_pulses = err_pulses;
    for (int f = 0; f < 8; f++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 2);
      if (kind == 1 && !(pmode == 1 || pmode == 2)) kind = 0;
      send_frame(b, pmode, par_bit(b, pmode) ^ (kind == 1), nstop, kind != 2);
      #40;
      if (kind == 0) exp_out = b;
      else begin
        exp_err = (kind == 1) ? 4'b0010 : 4'b0001;
        exp_pulses++;
      end
      n_checks += 4;
      if (bus.out !== exp_out) begin n_errors++; $display("FAIL rnd%0d_out: %h vs %h", f, bus.out, exp_out); end
      if (bus.error !== exp_err) begin n_errors++; $display("FAIL rnd%0d_error: %b vs %b", f, bus.error, exp_err); end
      if (err_pulses !== exp_pulses) begin
        n_errors++; $display("FAIL rnd%0d_pulses: %0d vs %0d", f, err_pulses, exp_pulses);
      end
      if (bus.ready_out !== (kind == 0)) begin
        n_errors++; $display("FAIL rnd%0d_ready: %b vs %b", f, bus.ready_out, kind == 0);
      end
      if (kind == 0) consume();
      #($urandom_range(1, 63));
    end
    n_checks++;
    if (wide_pulses !== 0) begin n_errors++; $display("FAIL ready_error_width: %0d wide vs 0", wide_pulses); end
  endtask

  initial begin
    test_reset();
    test_arming();
    test_stream();
    test_framing();
    test_parity();
    test_overrun();
    test_false_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
